// File: rtl/sdram_pkg.sv
// Shared constants for the SDRAM init/refresh scheduler: command encodings,
// FSM states and default timing at 75 MHz.
package sdram_pkg;

    // Command encodings as {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    // A10 high selects precharge-all
    localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

    // Default timing in clocks at 75 MHz
    localparam int DEF_INIT_CYCLES  = 15000;   // 200 us power-up wait
    localparam int DEF_REF_INTERVAL = 585;     // 7.8 us refresh period
    localparam int DEF_T_RP         = 2;
    localparam int DEF_T_RFC        = 7;
    localparam int DEF_T_MRD        = 2;
    localparam logic [12:0] DEF_MODE_REG = 13'h020;  // CL2, burst 1, sequential

    localparam int WAIT_W = 16;
    localparam int DEBT_W = 3;

    typedef enum logic [2:0] {
        INIT_WAIT,
        INIT_PRE,
        INIT_REF,
        LOAD_MODE,
        IDLE,
        GRANT,
        REF_PRE,
        REF
    } state_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval timer plus saturating count of refreshes owed.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_dec,
    output logic [DEBT_W-1:0] o_debt,
    output logic              o_expire
);

    localparam logic [WAIT_W-1:0] RELOAD   = WAIT_W'(REF_INTERVAL - 1);
    localparam logic [DEBT_W-1:0] DEBT_MAX = {DEBT_W{1'b1}};

    logic [WAIT_W-1:0] r_interval;
    logic [DEBT_W-1:0] r_debt;
    logic              w_expire;

    assign w_expire = i_en && (r_interval == '0);
    assign o_expire = w_expire;
    assign o_debt   = r_debt;

    // Down-counter: held at the reload value until enabled, then free-running
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_interval <= '0;
        end else if (!i_en || w_expire) begin
            r_interval <= RELOAD;
        end else begin
            r_interval <= r_interval - 1'b1;
        end
    end

    // Debt: +1 per expiry (saturating), -1 per completed refresh, both cancel
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_debt <= '0;
        end else begin
            case ({w_expire, i_dec})
                2'b10: if (r_debt != DEBT_MAX) r_debt <= r_debt + 1'b1;
                2'b01: if (r_debt != '0)       r_debt <= r_debt - 1'b1;
                default: r_debt <= r_debt;
            endcase
        end
    end

endmodule

// File: rtl/sdram_init_refresh_sched.sv
// SDRAM power-up initialisation and auto-refresh scheduler that arbitrates
// the command bus between itself and a single requester.
module sdram_init_refresh_sched
    import sdram_pkg::*;
#(
    parameter int          INIT_CYCLES  = DEF_INIT_CYCLES,
    parameter int          REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int          T_RP         = DEF_T_RP,
    parameter int          T_RFC        = DEF_T_RFC,
    parameter int          T_MRD        = DEF_T_MRD,
    parameter logic [12:0] MODE_REG     = DEF_MODE_REG
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        user_req,
    input  logic [3:0]  user_cmd,
    input  logic [1:0]  user_ba,
    input  logic [12:0] user_addr,
    output logic        user_gnt,
    output logic        ref_pending,
    output logic        init_done,
    output logic        sdram_cke,
    output logic [3:0]  sdram_cmd,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr
);

    // Last count value of each wait (a state lasting N clocks ends at N-1)
    localparam logic [WAIT_W-1:0] LAST_INIT = WAIT_W'(INIT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] CKE_ON    = WAIT_W'(INIT_CYCLES / 2);
    localparam logic [WAIT_W-1:0] LAST_RP   = WAIT_W'(T_RP - 1);
    localparam logic [WAIT_W-1:0] LAST_RFC  = WAIT_W'(T_RFC - 1);
    localparam logic [WAIT_W-1:0] LAST_MRD  = WAIT_W'(T_MRD - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_second_ref;
    logic              r_init_done;
    logic              w_wait_clr;
    logic              w_debt_dec;
    logic [DEBT_W-1:0] w_debt;
    logic              w_expire;

    sdram_ref_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_ref_timer (
        .i_clk    (sdram_clk),
        .i_rst    (sdram_rst),
        .i_en     (r_init_done),
        .i_dec    (w_debt_dec),
        .o_debt   (w_debt),
        .o_expire (w_expire)
    );

    // State, wait counter, init refresh count and init_done flag
    always_ff @(posedge sdram_clk or posedge sdram_rst) begin
        if (sdram_rst) begin
            r_state      <= INIT_WAIT;
            r_wait_cnt   <= '0;
            r_second_ref <= 1'b0;
            r_init_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_wait_clr) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != {WAIT_W{1'b1}}) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_state == INIT_REF && r_wait_cnt == LAST_RFC) begin
                r_second_ref <= !r_second_ref;
            end
            if (r_state == LOAD_MODE && w_state_next == IDLE) begin
                r_init_done <= 1'b1;
            end
        end
    end

    // Next-state logic; every state change restarts the wait counter
    always_comb begin
        w_state_next = r_state;
        w_wait_clr   = 1'b0;
        w_debt_dec   = 1'b0;
        case (r_state)
            INIT_WAIT: if (r_wait_cnt == LAST_INIT) begin
                w_state_next = INIT_PRE;
                w_wait_clr   = 1'b1;
            end
            INIT_PRE: if (r_wait_cnt == LAST_RP) begin
                w_state_next = INIT_REF;
                w_wait_clr   = 1'b1;
            end
            INIT_REF: if (r_wait_cnt == LAST_RFC) begin
                w_wait_clr = 1'b1;
                if (r_second_ref) w_state_next = LOAD_MODE;
            end
            LOAD_MODE: if (r_wait_cnt == LAST_MRD) begin
                w_state_next = IDLE;
                w_wait_clr   = 1'b1;
            end
            IDLE: begin
                // Owed refresh wins over a simultaneous request
                if (w_debt != '0) begin
                    w_state_next = REF_PRE;
                    w_wait_clr   = 1'b1;
                end else if (user_req) begin
                    w_state_next = GRANT;
                    w_wait_clr   = 1'b1;
                end
            end
            GRANT: if (!user_req) begin
                w_state_next = IDLE;
                w_wait_clr   = 1'b1;
            end
            REF_PRE: if (r_wait_cnt == LAST_RP) begin
                w_state_next = REF;
                w_wait_clr   = 1'b1;
            end
            REF: if (r_wait_cnt == LAST_RFC) begin
                w_debt_dec = 1'b1;
                w_wait_clr = 1'b1;
                // Debt after this decrement is zero only if it was 1 and no
                // expiry lands in the same cycle
                if (w_debt == DEBT_W'(1) && !w_expire) w_state_next = IDLE;
            end
            default: begin
                w_state_next = INIT_WAIT;
                w_wait_clr   = 1'b1;
            end
        endcase
    end

    // Output mux: command on the first cycle of each command state, NOP after
    always_comb begin
        sdram_cke  = 1'b1;
        sdram_cmd  = CMD_NOP;
        sdram_ba   = 2'b00;
        sdram_addr = '0;
        case (r_state)
            INIT_WAIT: sdram_cke = (r_wait_cnt >= CKE_ON);
            INIT_PRE, REF_PRE: if (r_wait_cnt == '0) begin
                sdram_cmd  = CMD_PRE;
                sdram_addr = PRE_ALL_ADDR;
            end
            INIT_REF, REF: if (r_wait_cnt == '0) begin
                sdram_cmd = CMD_REF;
            end
            LOAD_MODE: if (r_wait_cnt == '0) begin
                sdram_cmd  = CMD_LMR;
                sdram_addr = MODE_REG;
            end
            GRANT: if (user_req) begin
                sdram_cmd  = user_cmd;
                sdram_ba   = user_ba;
                sdram_addr = user_addr;
            end
            default: sdram_cmd = CMD_NOP;
        endcase
    end

    assign user_gnt    = (r_state == GRANT);
    assign ref_pending = (w_debt != '0);
    assign init_done   = r_init_done;

endmodule
